// File: rtl/mcycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle EX scheduler.
package mcycle_ctrl_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DWORD_W = 64;
  localparam int unsigned STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MACC     = 2'b01,
    ST_DIV_WAIT = 2'b10,
    ST_DIVZ     = 2'b11
  } mc_state_e;

  typedef enum logic [1:0] {
    MC_MADD = 2'b00,
    MC_MSUB = 2'b01,
    MC_DIV  = 2'b10,
    MC_DIVU = 2'b11
  } mc_kind_e;

  typedef struct packed {
    logic [WORD_W-1:0] hi;
    logic [WORD_W-1:0] lo;
  } hilo_t;

  function automatic logic kind_is_div(input logic [1:0] kind);
    return (kind == MC_DIV) || (kind == MC_DIVU);
  endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// EX / divider / pipeline-control signals seen by the multi-cycle scheduler.
interface mcycle_ctrl_if import mcycle_ctrl_pkg::*; ();

  logic                stallreq_id;
  logic                flush;
  logic                ex_mc_valid;
  logic [1:0]          ex_mc_kind;
  logic [DWORD_W-1:0]  ex_mul_prod;
  logic [WORD_W-1:0]   ex_opdata1;
  logic [WORD_W-1:0]   ex_opdata2;
  hilo_t               hilo_cur;
  logic                div_ready;
  hilo_t               div_result;
  logic                div_start;
  logic                div_signed;
  logic                div_annul;
  logic                mc_done;
  hilo_t               mc_result;
  logic [STALL_W-1:0]  stall;

  modport slave (
    input  stallreq_id, flush, ex_mc_valid, ex_mc_kind, ex_mul_prod,
           ex_opdata1, ex_opdata2, hilo_cur, div_ready, div_result,
    output div_start, div_signed, div_annul, mc_done, mc_result, stall
  );

  modport master (
    output stallreq_id, flush, ex_mc_valid, ex_mc_kind, ex_mul_prod,
           ex_opdata1, ex_opdata2, hilo_cur, div_ready, div_result,
    input  div_start, div_signed, div_annul, mc_done, mc_result, stall
  );

endinterface

// File: rtl/mcycle_ctrl_acc.sv
// 64-bit HI/LO accumulate: hilo +/- latched product, modulo 2^64.
module mcycle_ctrl_acc import mcycle_ctrl_pkg::*; (
  input  logic [DWORD_W-1:0] i_hilo,
  input  logic [DWORD_W-1:0] i_tmp,
  input  logic               i_sub,
  output logic [DWORD_W-1:0] o_res
);

  assign o_res = i_sub ? (i_hilo - i_tmp) : (i_hilo + i_tmp);

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle EX scheduler: MADD/MSUB accumulate, optional DIV/DIVU handshake,
// pipeline stall vector. Define MCYCLE_DIV_EN to build divider sequencing.
module mcycle_ctrl import mcycle_ctrl_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  mcycle_ctrl_if.slave bus
);

  mc_state_e          r_state;
  logic [DWORD_W-1:0] r_tmp;
  logic               r_sub;
  logic               r_done_q;

  logic               w_kind_en;
  logic               w_start;
  logic               w_ex_req;
  logic               w_mc_done;
  logic [DWORD_W-1:0] w_result;
  logic [DWORD_W-1:0] w_acc;
  logic               w_unused;

  mcycle_ctrl_acc u_mc_acc (
    .i_hilo (DWORD_W'(bus.hilo_cur)),
    .i_tmp  (r_tmp),
    .i_sub  (r_sub),
    .o_res  (w_acc)
  );

`ifdef MCYCLE_DIV_EN
  logic w_div_start;

  assign w_kind_en   = 1'b1;
  assign w_div_start = w_start & ~bus.flush & kind_is_div(bus.ex_mc_kind) &
                       (bus.ex_opdata2 != '0);
  assign bus.div_start  = w_div_start;
  assign bus.div_signed = w_div_start & (bus.ex_mc_kind == MC_DIV);
  assign bus.div_annul  = bus.flush & (r_state == ST_DIV_WAIT);
  // Dividend goes straight from EX to the divider.
  assign w_unused = ^bus.ex_opdata1;
`else
  assign w_kind_en      = ~kind_is_div(bus.ex_mc_kind);
  assign bus.div_start  = 1'b0;
  assign bus.div_signed = 1'b0;
  assign bus.div_annul  = 1'b0;
  assign w_unused = ^{bus.ex_opdata1, bus.ex_opdata2, bus.div_ready, bus.div_result};
`endif

  // done_q blocks the instruction just leaving EX from retriggering.
  assign w_start = ~rst & (r_state == ST_IDLE) & bus.ex_mc_valid & ~r_done_q & w_kind_en;

  always_comb begin
    w_mc_done = 1'b0;
    w_result  = '0;
    case (r_state)
      ST_MACC: begin
        w_mc_done = 1'b1;
        w_result  = w_acc;
      end
`ifdef MCYCLE_DIV_EN
      ST_DIV_WAIT: begin
        if (bus.div_ready) begin
          w_mc_done = 1'b1;
          w_result  = DWORD_W'(bus.div_result);
        end
      end
      ST_DIVZ: w_mc_done = 1'b1;
`endif
      default: ;
    endcase
    if (bus.flush) begin
      w_mc_done = 1'b0;
      w_result  = '0;
    end
  end

  assign w_ex_req = ~rst & ~bus.flush &
                    (w_start | ((r_state != ST_IDLE) & ~w_mc_done));

  assign bus.stall     = rst         ? STALL_NONE :
                         w_ex_req    ? STALL_EX   :
                         bus.stallreq_id ? STALL_ID : STALL_NONE;
  assign bus.mc_done   = w_mc_done;
  assign bus.mc_result = hilo_t'(w_result);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tmp    <= '0;
      r_sub    <= 1'b0;
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= w_mc_done;
      if (bus.flush) begin
        r_state <= ST_IDLE;
        r_tmp   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_state <= ST_MACC;
              r_tmp   <= bus.ex_mul_prod;
              r_sub   <= (bus.ex_mc_kind == MC_MSUB);
`ifdef MCYCLE_DIV_EN
              if (kind_is_div(bus.ex_mc_kind))
                r_state <= (bus.ex_opdata2 == '0) ? ST_DIVZ : ST_DIV_WAIT;
`endif
            end
          end
          ST_MACC: r_state <= ST_IDLE;
`ifdef MCYCLE_DIV_EN
          ST_DIV_WAIT: if (bus.div_ready) r_state <= ST_IDLE;
          ST_DIVZ:     r_state <= ST_IDLE;
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed + randomized bench for mcycle_ctrl; follows MCYCLE_DIV_EN of the build.
module tb_mcycle_ctrl;
  import mcycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mcycle_ctrl_if bus();

  mcycle_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample one cycle mid-period, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [5:0] e_stall, input logic e_done,
                     input logic [63:0] e_res, input logic e_start, input logic e_signed,
                     input logic e_annul);
    @(negedge clk);
    chk({tag, ".stall"}, 64'(bus.stall), 64'(e_stall));
    chk({tag, ".done"}, 64'(bus.mc_done), 64'(e_done));
    if (e_done) chk({tag, ".result"}, bus.mc_result, e_res);
    chk({tag, ".div_start"}, 64'(bus.div_start), 64'(e_start));
    if (e_start) chk({tag, ".div_signed"}, 64'(bus.div_signed), 64'(e_signed));
    chk({tag, ".div_annul"}, 64'(bus.div_annul), 64'(e_annul));
    tick();
  endtask

  function automatic logic [5:0] idle_stall(input logic sreq);
    return sreq ? 6'b000111 : 6'b000000;
  endfunction

  logic [1:0]  k;
  logic [63:0] prod_l, exp_res;
  logic        sreq;
`ifdef MCYCLE_DIV_EN
  logic [31:0] a, b, q, r;
  int          lat;
`endif

  initial begin
    rst = 1'b1;
    bus.stallreq_id = 1'b0; bus.flush = 1'b0; bus.ex_mc_valid = 1'b0;
    bus.ex_mc_kind = 2'b00; bus.ex_mul_prod = '0; bus.ex_opdata1 = '0;
    bus.ex_opdata2 = '0; bus.hilo_cur = '0; bus.div_ready = 1'b0; bus.div_result = '0;
    #12;
    chk("reset.stall", 64'(bus.stall), 64'h0);
    chk("reset.done", 64'(bus.mc_done), 64'h0);
    chk("reset.result", bus.mc_result, 64'h0);
    chk("reset.div_start", 64'(bus.div_start), 64'h0);
    rst = 1'b0;
    tick();

    // MADD 1 + 5
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b00; bus.hilo_cur = 64'h1; bus.ex_mul_prod = 64'h5;
    cyc("madd_n",    6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc("madd_n1",   6'b000000, 1'b1, 64'h6, 1'b0, 1'b0, 1'b0);
    cyc("madd_hold", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.ex_mc_valid = 1'b0;
    cyc("madd_idle", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // MSUB 0 - 1 wraps
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b01; bus.hilo_cur = 64'h0; bus.ex_mul_prod = 64'h1;
    cyc("msub_n",  6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc("msub_n1", 6'b000000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    bus.ex_mc_valid = 1'b0;
    cyc("msub_idle", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // ID stall request idle and while busy
    bus.stallreq_id = 1'b1;
    cyc("sreq_idle", 6'b000111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b00; bus.hilo_cur = 64'h3; bus.ex_mul_prod = 64'h2;
    cyc("sreq_busy", 6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc("sreq_done", 6'b000111, 1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
    bus.ex_mc_valid = 1'b0; bus.stallreq_id = 1'b0;
    cyc("sreq_idle2", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // flush in MACC kills mc_done and stall
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b00; bus.hilo_cur = 64'h7; bus.ex_mul_prod = 64'h8;
    cyc("flm_n", 6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    cyc("flm_flush", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b0; bus.ex_mc_valid = 1'b0;
    cyc("flm_after", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // async reset mid-MACC
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b00; bus.hilo_cur = 64'h1; bus.ex_mul_prod = 64'h9;
    cyc("arst_n", 6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst.stall", 64'(bus.stall), 64'h0);
    chk("arst.done", 64'(bus.mc_done), 64'h0);
    chk("arst.result", bus.mc_result, 64'h0);
    bus.ex_mc_valid = 1'b0;
    #1 rst = 1'b0;
    tick();
    cyc("arst_after", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

`ifdef MCYCLE_DIV_EN
    // DIV 7/2, divider answers 3 cycles after start
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b10; bus.ex_opdata1 = 32'd7; bus.ex_opdata2 = 32'd2;
    cyc("div_start", 6'b001111, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    cyc("div_w1",    6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc("div_w2",    6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.div_ready = 1'b1; bus.div_result = {32'd1, 32'd3};
    cyc("div_done",  6'b000000, 1'b1, {32'd1, 32'd3}, 1'b0, 1'b0, 1'b0);
    bus.div_ready = 1'b0;
    cyc("div_noretrig", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.ex_mc_valid = 1'b0;
    cyc("div_idle",  6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // DIVU by zero
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b11; bus.ex_opdata1 = 32'd5; bus.ex_opdata2 = 32'd0;
    cyc("divz_n",  6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc("divz_n1", 6'b000000, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.ex_mc_valid = 1'b0;
    cyc("divz_idle", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // flush in DIV_WAIT against a same-cycle div_ready
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b10; bus.ex_opdata1 = 32'd100; bus.ex_opdata2 = 32'd7;
    cyc("fld_start", 6'b001111, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    cyc("fld_wait",  6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1; bus.div_ready = 1'b1; bus.div_result = {32'd2, 32'd14};
    cyc("fld_flush", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    bus.flush = 1'b0; bus.div_ready = 1'b0; bus.ex_mc_valid = 1'b0;
    cyc("fld_after", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
`else
    // divide kinds ignored without the divider feature
    bus.ex_mc_valid = 1'b1; bus.ex_mc_kind = 2'b10; bus.ex_opdata1 = 32'd7; bus.ex_opdata2 = 32'd2;
    cyc("divoff_n",  6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.ex_mc_kind = 2'b11; bus.div_ready = 1'b1;
    cyc("divoff_n1", 6'b000000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.ex_mc_valid = 1'b0; bus.div_ready = 1'b0;
`endif

    // randomized op stream against the behavioural model
    for (int i = 0; i < 80; i++) begin
      k = 2'($urandom_range(0, 3));
      bus.ex_mc_valid = 1'b1;
      bus.ex_mc_kind  = k;
      bus.stallreq_id = 1'($urandom_range(0, 1));
      bus.ex_mul_prod = {$urandom, $urandom};
      bus.hilo_cur    = {$urandom, $urandom};
      bus.ex_opdata1  = $urandom;
      bus.ex_opdata2  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (!kind_is_div(k)) begin
        prod_l = bus.ex_mul_prod;
        cyc("r_mac_n", 6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        // live inputs move: result must use latched product and current HI/LO
        bus.hilo_cur    = {$urandom, $urandom};
        bus.ex_mul_prod = {$urandom, $urandom};
        sreq = 1'($urandom_range(0, 1));
        bus.stallreq_id = sreq;
        exp_res = (k == 2'b01) ? (64'(bus.hilo_cur) - prod_l) : (64'(bus.hilo_cur) + prod_l);
        cyc("r_mac_done", idle_stall(sreq), 1'b1, exp_res, 1'b0, 1'b0, 1'b0);
      end
`ifdef MCYCLE_DIV_EN
      else if (bus.ex_opdata2 == 32'd0) begin
        cyc("r_divz_n", 6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        sreq = 1'($urandom_range(0, 1));
        bus.stallreq_id = sreq;
        cyc("r_divz_done", idle_stall(sreq), 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
      end else begin
        if (k == 2'b10 && bus.ex_opdata2 == 32'hFFFF_FFFF) bus.ex_opdata2 = 32'd3;
        a = bus.ex_opdata1; b = bus.ex_opdata2;
        if (k == 2'b10) begin
          q = 32'($signed(a) / $signed(b));
          r = 32'($signed(a) % $signed(b));
        end else begin
          q = a / b;
          r = a % b;
        end
        lat = $urandom_range(1, 4);
        cyc("r_div_start", 6'b001111, 1'b0, 64'h0, 1'b1, (k == 2'b10), 1'b0);
        for (int j = 1; j < lat; j++) begin
          bus.stallreq_id = 1'($urandom_range(0, 1));
          cyc("r_div_wait", 6'b001111, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        end
        sreq = 1'($urandom_range(0, 1));
        bus.stallreq_id = sreq;
        bus.div_ready = 1'b1;
        bus.div_result = {r, q};
        cyc("r_div_done", idle_stall(sreq), 1'b1, {r, q}, 1'b0, 1'b0, 1'b0);
        bus.div_ready = 1'b0;
      end
`else
      else begin
        sreq = bus.stallreq_id;
        cyc("r_divoff", idle_stall(sreq), 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      end
`endif
      // instruction still in EX for one more cycle must not retrigger
      sreq = 1'($urandom_range(0, 1));
      bus.stallreq_id = sreq;
      cyc("r_gap", idle_stall(sreq), 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
